// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RISC-V pipeline.
// Keeps a shadow copy of the E/M/W register-usage fields, so it only needs the decode fields and the execute redirect.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             regWriteD,
  input  logic [1:0]       resultSrcD,
  input  logic [1:0]       PCSrcE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic [1:0] result_src;
  } stage_t;

  stage_t           e_q, e_d, m_q, m_d, w_q, w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             redirect;
  logic             unused_fields;

  // A loaded or PC+4 value in M is not ready yet; the load-use stall keeps that case from reaching E.
  function automatic logic [1:0] fwd_sel(input logic [4:0] x, input stage_t m, input stage_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (x != '0 && m.reg_write && m.rd == x && m.result_src == 2'b11)
      sel = 2'b11;
    else if (x != '0 && m.reg_write && m.rd == x && m.result_src == 2'b00)
      sel = 2'b10;
    else if (x != '0 && w.reg_write && w.rd == x)
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    load_use = e_q.reg_write
             && (e_q.result_src == 2'b01 || e_q.result_src == 2'b10)
             && e_q.rd != '0
             && (e_q.rd == Rs1D || e_q.rd == Rs2D);
    redirect = PCSrcE != 2'b00;

    forwardAE = 2'b00;
    forwardBE = 2'b00;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    if (rst) begin
      forwardAE = fwd_sel(e_q.rs1, m_q, w_q);
      forwardBE = fwd_sel(e_q.rs2, m_q, w_q);
      // A redirect squashes the decode instruction, so it overrides any stall.
      stallF    = load_use && !redirect;
      stallD    = load_use && !redirect;
      flushD    = redirect;
      flushE    = redirect || load_use;
    end
  end

  always_comb begin
    e_d = flushE ? '0 : '{rs1: Rs1D, rs2: Rs2D, rd: RdD,
                          reg_write: regWriteD, result_src: resultSrcD};
    m_d = e_q;
    w_d = m_q;

    stall_cnt_d = stall_cnt_q;
    if (stallD && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (flushD && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;

  // Shadow fields kept for completeness but not consulted by any rule.
  assign unused_fields = ^{m_q.rs1, m_q.rs2, w_q.rs1, w_q.rs2, w_q.result_src};

endmodule
